// File: rtl/dmem_responder.sv
`default_nettype none
// =============================================================================
// dmem_responder : word RAM plus a memory-mapped console TX FIFO and status
//                  register; optional CYCLE counter under DMEM_CYCLE_COUNTER_EN
// Revision      : 1.0  initial release
// =============================================================================
module dmem_responder #(
   parameter int RAM_AW  = 12,
   parameter int FIFO_AW = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q_dmem,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int RAM_WORDS  = 2**RAM_AW;
   localparam int FIFO_DEPTH = 2**FIFO_AW;
   localparam logic [31:0]      C_ADDR_TXDATA = 32'h0000_1000;
   localparam logic [31:0]      C_ADDR_STATUS = 32'h0000_1001;
   localparam logic [FIFO_AW:0] C_FULL_COUNT  = {1'b1, {FIFO_AW{1'b0}}};

   logic [31:0]        r_mem [RAM_WORDS];
   logic [31:0]        r_ram_q;
   logic [31:0]        r_io_q;
   logic               r_sel_ram;
   logic [7:0]         r_fifo [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_ovf;

   logic               w_is_ram;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_accept;
   logic               w_ovf_set;
   logic               w_ovf_clr;
   logic [31:0]        w_status;
   logic [31:0]        w_io_rdata;

`ifdef DMEM_CYCLE_COUNTER_EN
   localparam logic [31:0] C_ADDR_CYCLE = 32'h0000_1002;
   logic [31:0]        r_cycle;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_cycle <= '0;
      else        r_cycle <= r_cycle + 32'd1;
   end
`endif

   assign w_is_ram  = (address_dmem >> RAM_AW) == 32'd0;
   assign w_full    = (r_count == C_FULL_COUNT);
   assign w_empty   = (r_count == '0);
   assign w_push    = wren && (address_dmem == C_ADDR_TXDATA);
   assign w_pop     = !w_empty && tx_ready;
   // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
   assign w_accept  = w_push && (!w_full || w_pop);
   assign w_ovf_set = w_push && w_full && !w_pop;
   assign w_ovf_clr = wren && (address_dmem == C_ADDR_STATUS);

   assign w_status  = {{(23-FIFO_AW){1'b0}}, r_count, 5'b0, r_ovf, w_empty, w_full};

   always_comb begin
      w_io_rdata = 32'h0;
      case (address_dmem)
         C_ADDR_STATUS: w_io_rdata = w_status;
`ifdef DMEM_CYCLE_COUNTER_EN
         C_ADDR_CYCLE:  w_io_rdata = r_cycle;
`endif
         default:       w_io_rdata = 32'h0;
      endcase
   end

   // RAM kept free of reset so it maps onto block RAM; read returns pre-write data.
   always_ff @(posedge clock) begin
      if (wren && w_is_ram) r_mem[address_dmem[RAM_AW-1:0]] <= data;
      r_ram_q <= r_mem[address_dmem[RAM_AW-1:0]];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sel_ram <= 1'b0;
         r_io_q    <= '0;
      end else begin
         r_sel_ram <= w_is_ram;
         r_io_q    <= w_io_rdata;
      end
   end

   assign q_dmem = r_sel_ram ? r_ram_q : r_io_q;

   always_ff @(posedge clock) begin
      if (w_accept) r_fifo[r_wr_ptr] <= data[7:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_ovf_set)      r_ovf <= 1'b1;
         else if (w_ovf_clr) r_ovf <= 1'b0;
      end
   end

   assign tx_valid = !w_empty;
   assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// =============================================================================
// tb_dmem_responder : scoreboard bench for dmem_responder (RAM, TX FIFO, STATUS)
// Revision          : 1.0  initial release
// =============================================================================
module tb_dmem_responder;

   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   always #5 clock = ~clock;

   dmem_responder #(.RAM_AW(12), .FIFO_AW(3)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_dmem       (q_dmem),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [32:0] q_exp [$];               // bit 32 = value is known
   logic [31:0] m_ram [logic [31:0]];
   logic [7:0]  m_fifo [$];
   logic        m_ovf = 1'b0;
   logic [31:0] m_cycle;

   always @(posedge clock or negedge reset) begin
      if (!reset) m_cycle <= '0;
      else        m_cycle <= m_cycle + 32'd1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] status_model();
      int cnt = m_fifo.size();
      return (32'(cnt) << 8) | {29'b0, m_ovf, cnt == 0, cnt == DEPTH};
   endfunction

   function automatic logic [32:0] exp_read(input logic [31:0] a);
      if (a < 32'h1000) begin
         if (m_ram.exists(a)) return {1'b1, m_ram[a]};
         return 33'h0;
      end
      if (a == 32'h1001) return {1'b1, status_model()};
`ifdef DMEM_CYCLE_COUNTER_EN
      if (a == 32'h1002) return {1'b1, m_cycle};
`endif
      return {1'b1, 32'h0};
   endfunction

   // One bus cycle: drive, predict from pre-edge model state, update model, compare.
   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
      logic [32:0] e;
      logic        pop;
      logic        full;
      address_dmem = a;
      data         = d;
      wren         = we;
      tx_ready     = rdy;
      q_exp.push_back(exp_read(a));
      pop  = (m_fifo.size() != 0) && rdy;
      full = (m_fifo.size() == DEPTH);
      if (pop) void'(m_fifo.pop_front());
      if (we && a == 32'h1000) begin
         if (full && !pop) m_ovf = 1'b1;
         else              m_fifo.push_back(d[7:0]);
      end
      if (we && a == 32'h1001) m_ovf = 1'b0;
      if (we && a < 32'h1000)  m_ram[a] = d;
      @(posedge clock);
      #1;
      e = q_exp.pop_front();
      if (e[32]) check_val("q_dmem", q_dmem, e[31:0]);
      check_val("tx_valid", {31'b0, tx_valid}, 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) check_val("tx_data", {24'b0, tx_data}, {24'b0, m_fifo[0]});
   endtask

   logic [7:0]  drain_exp [8];
   logic [31:0] v1;
   logic [31:0] v2;

   initial begin
      drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};
      reset = 1'b0; address_dmem = '0; data = '0; wren = 1'b0; tx_ready = 1'b0;
      @(posedge clock);
      #1;
      check_val("rst_q_dmem", q_dmem, 32'h0);
      check_val("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      check_val("rst_tx_data", {24'b0, tx_data}, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // RAM store/load, unmapped read, read-during-write
      cyc(32'h005, 32'hDEADBEEF, 1'b1, 1'b0);
      cyc(32'h005, 32'h0, 1'b0, 1'b0);
      check_val("ram_load", q_dmem, 32'hDEADBEEF);
      cyc(32'h1005, 32'h1234, 1'b1, 1'b0);
      check_val("unmapped", q_dmem, 32'h0);
      cyc(32'h010, 32'h1, 1'b1, 1'b0);
      cyc(32'h010, 32'h2, 1'b1, 1'b0);
      check_val("rdw_old", q_dmem, 32'h1);
      cyc(32'h010, 32'h0, 1'b0, 1'b1);
      check_val("rdw_new", q_dmem, 32'h2);

      // Fill FIFO with consumer stalled, overflow, clear
      for (int i = 0; i < 8; i++) cyc(32'h1000, 32'h41 + i, 1'b1, 1'b0);
      check_val("txdata_rd", q_dmem, 32'h0);
      cyc(32'h1001, 32'h0, 1'b0, 1'b0);
      check_val("status_full", q_dmem, 32'h801);
      cyc(32'h1000, 32'h49, 1'b1, 1'b0);
      cyc(32'h1001, 32'h0, 1'b0, 1'b0);
      check_val("status_ovf", q_dmem, 32'h805);
      cyc(32'h1001, 32'hFFFF_FFFF, 1'b1, 1'b0);
      cyc(32'h1001, 32'h0, 1'b0, 1'b0);
      check_val("status_clr", q_dmem, 32'h801);

      // Simultaneous push/pop while full, then drain
      cyc(32'h1000, 32'h50, 1'b1, 1'b1);
      cyc(32'h1001, 32'h0, 1'b0, 1'b0);
      check_val("status_pp", q_dmem, 32'h801);
      for (int i = 0; i < 8; i++) begin
         check_val("drain", {24'b0, tx_data}, {24'b0, drain_exp[i]});
         cyc(32'h2000, 32'h0, 1'b0, 1'b1);
      end
      cyc(32'h1001, 32'h0, 1'b0, 1'b1);
      check_val("status_empty", q_dmem, 32'h2);

      // Non-full push+pop, stall stability
      cyc(32'h1000, 32'h61, 1'b1, 1'b0);
      cyc(32'h1000, 32'h62, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cyc(32'h1001, 32'h0, 1'b0, 1'b0);
      check_val("pp_count", q_dmem, 32'h100);
      cyc(32'h2000, 32'h0, 1'b0, 1'b1);

      // Cycle counter
      cyc(32'h1002, 32'h0, 1'b0, 1'b0);
      v1 = q_dmem;
      for (int i = 0; i < 9; i++) cyc(32'h2000, 32'h0, 1'b0, 1'b0);
      cyc(32'h1002, 32'h5555, 1'b1, 1'b0);
      v2 = q_dmem;
`ifdef DMEM_CYCLE_COUNTER_EN
      check_val("cycle_delta", v2 - v1, 32'd10);
`else
      check_val("cycle_off", v2, 32'h0);
`endif

      // Reset mid-operation
      for (int i = 0; i < 3; i++) cyc(32'h1000, 32'h71 + i, 1'b1, 1'b0);
      address_dmem = 32'h2000; wren = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      check_val("midrst_valid", {31'b0, tx_valid}, 32'h0);
      check_val("midrst_q", q_dmem, 32'h0);
      m_fifo.delete();
      m_ovf = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      cyc(32'h1001, 32'h0, 1'b0, 1'b0);
      check_val("post_rst_status", q_dmem, 32'h2);
      cyc(32'h005, 32'h0, 1'b0, 1'b0);
      check_val("ram_kept", q_dmem, 32'hDEADBEEF);
      cyc(32'h1000, 32'h77, 1'b1, 1'b1);
      check_val("first_push", {24'b0, tx_data}, 32'h77);
      cyc(32'h2000, 32'h0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
